wb_stream_master: RTL
=====================

# wb_stream_master

Byte-stream-to-Wishbone bridge that acts as a bus master, the initiating end of the pipelined Wishbone protocol that the SoC's slaves respond to. It consumes command frames from an 8-bit valid/ready receive stream, normally fed by the UART receiver. For each frame it issues one single-word Wishbone read or write and returns status and read data on an 8-bit transmit stream. It occupies a spare master slot on the shared-bus interconnect and gives a host debug/load access to memory and peripherals.

## Interface
- TIMEOUT, 1024: cycles allowed from first `stb` assertion to `ack`/`err` before the transfer is abandoned; must be ≥ 1.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb  wb_if master modport  —  pipelined Wishbone master.
  - Drives: cyc, stb, we, adr[31:0], dat_m[31:0], sel[3:0].
  - Samples: dat_s[31:0], stall, ack, err.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts a byte when rx_valid & rx_ready.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts a byte when tx_valid & tx_ready.

## Operation
- Frame formats, all multi-byte fields LSB first:
  - Write: 0x01, A0..A3, D0..D3.
  - Read: 0x02, A0..A3.
- Responses:
  - Write: one status byte.
  - Read: status byte then R0..R3. R bytes are 0x00 when status ≠ 0x00.
  - Status codes: 0x00 ack, 0x01 err, 0x02 timeout.
  - Any other command byte: single response 0xFF, no bus access, return to IDLE.
- `adr` is the 32-bit address as received; low 2 bits are passed through. `sel` is always 4'hF. `we` = 1 for write.
- FSM: IDLE → ADDR → (WDATA if write) → REQ → WAIT → RESP → IDLE; also IDLE → RESP on a bad command.
  - IDLE: rx_ready=1; latch command.
  - ADDR/WDATA: rx_ready=1; a 2-bit byte counter shifts bytes into the address/data registers. The counter wraps to 0 on the 4th byte, which advances the state.
  - REQ: cyc=stb=1. When stall=0 the request is accepted; stb drops next cycle, cyc stays high; go to WAIT.
  - WAIT: cyc=1, stb=0 until ack, err or timeout.
  - RESP: present bytes in order; advance only on tx_valid & tx_ready.
- Timeout counter:
  - Clears on entering REQ and increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no ack/err: drop cyc/stb, status 0x02.
- Termination priority in the same cycle: ack > err > timeout.
- ack/err may arrive in the same cycle stb is accepted; the transfer then completes with no WAIT cycles.
- ack/err while cyc=0 is ignored.
- Read data is latched from dat_s in the ack cycle.
- rx_ready=0 in REQ, WAIT and RESP. Bytes offered then are held off, not dropped.

## Timing
- Reset values (async, on rst_n low):
  - State IDLE.
  - cyc=stb=we=0, adr=0, dat_m=0, sel=4'hF.
  - tx_valid=0, tx_data=0, rx_ready=1.
  - Counters cleared.
- Reset mid-transfer drops cyc/stb immediately (asynchronously); the partial frame is discarded.
- cyc/stb rise on the clock edge after the last frame byte is accepted.
- Write, zero wait states, stall=0, ack in the first stb cycle: status tx_valid rises the cycle after ack.
- tx_data/tx_valid are registered and held stable while tx_valid & !tx_ready.
- Back-to-back response bytes go out on consecutive cycles when tx_ready=1.
- After the last response byte handshake, rx_ready=1 on the next cycle.
- dat_m/adr/we are stable from cyc rise until cyc falls.
- Timeout: cyc falls exactly TIMEOUT+1 cycles after entering REQ if no termination occurs.

## Test plan
- Write 0x01, 00 00 01 10, EF BE AD DE; slave acks after 2 cycles → adr=0x10010000, dat_m=0xDEADBEEF, we=1, sel=F; response 0x00.
- Read 0x02, 04 00 00 00; slave stalls 3 cycles, acks with 0x12345678 → response 00 78 56 34 12; stb drops one cycle after stall falls.
- Read with slave asserting err → response 01 00 00 00 00; cyc low one cycle after err.
- No response, TIMEOUT=16 → cyc high 17 cycles, response 0x02 (write) or 02 00 00 00 00 (read).
- Bad command 0x7E → response 0xFF, cyc never asserted. Then a valid read succeeds; tx_ready held low 5 cycles → tx_data stable throughout.
- rst_n pulsed low mid-WAIT → cyc/stb/tx_valid low immediately; the next full frame completes normally.

Source files
------------

// File: rtl/wb_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_master
// Description : Byte-stream to pipelined-Wishbone bus master bridge.
//               Command frames arrive on an 8-bit valid/ready receive
//               stream. Each frame produces one single-word Wishbone
//               read or write. Status and read data go back on an 8-bit
//               valid/ready transmit stream.
//
//               Frames (multi-byte fields LSB first):
//                 write : 0x01 A0 A1 A2 A3 D0 D1 D2 D3 -> status
//                 read  : 0x02 A0 A1 A2 A3             -> status R0..R3
//                 other : any byte                     -> 0xFF
//               Status: 0x00 ack, 0x01 err, 0x02 timeout.
//
// Ports       : clk, rst_n               clock, async active-low reset
//               wb_cyc/stb/we/adr/dat_m/sel   Wishbone master outputs
//               wb_dat_s/stall/ack/err        Wishbone master inputs
//               rx_data/rx_valid/rx_ready     command byte stream (in)
//               tx_data/tx_valid/tx_ready     response byte stream (out)
// Parameters  : TIMEOUT  cycles from first stb to ack/err before the
//                        transfer is abandoned (>= 1)
// Revision    : 1.0  initial release
// ============================================================================
module wb_stream_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,

    // Wishbone pipelined master
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_m,
    output logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_s,
    input  logic        wb_stall,
    input  logic        wb_ack,
    input  logic        wb_err,

    // Command byte stream
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,

    // Response byte stream
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [7:0] c_CMD_WRITE   = 8'h01;
    localparam logic [7:0] c_CMD_READ    = 8'h02;
    localparam logic [7:0] c_ST_ACK      = 8'h00;
    localparam logic [7:0] c_ST_ERR      = 8'h01;
    localparam logic [7:0] c_ST_TIMEOUT  = 8'h02;
    localparam logic [7:0] c_ST_BAD_CMD  = 8'hFF;

    // Counter must hold the value TIMEOUT itself.
    localparam int             c_TW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [1:0]      r_byte_cnt;   // byte position inside ADDR/WDATA field
    logic            r_is_write;
    logic [31:0]     r_rdata;      // read data, shifted out LSB first
    logic [c_TW-1:0] r_tcount;     // cycles spent in REQ/WAIT
    logic [2:0]      r_resp_left;  // response bytes remaining after tx_data

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic       w_rx_fire;
    logic       w_tx_fire;
    logic       w_timeout;
    logic       w_terminate;
    logic [7:0] w_status;

    assign w_rx_fire   = rx_valid & rx_ready;
    assign w_tx_fire   = tx_valid & tx_ready;
    assign w_timeout   = (r_tcount == c_TIMEOUT);
    assign w_terminate = wb_ack | wb_err | w_timeout;

    // ack wins over err, err wins over timeout when they coincide.
    always_comb begin
        w_status = c_ST_TIMEOUT;
        if (wb_ack) begin
            w_status = c_ST_ACK;
        end else if (wb_err) begin
            w_status = c_ST_ERR;
        end
    end

    // Only full-word accesses are issued.
    assign wb_sel = 4'hF;

    // ------------------------------------------------------------------
    // Main FSM; every output is registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_is_write  <= 1'b0;
            r_rdata     <= 32'd0;
            r_tcount    <= '0;
            r_resp_left <= 3'd0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= 32'd0;
            wb_dat_m    <= 32'd0;
            rx_ready    <= 1'b1;
            tx_data     <= 8'd0;
            tx_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_byte_cnt <= 2'd0;
                    if (w_rx_fire) begin
                        if (rx_data == c_CMD_WRITE) begin
                            r_is_write <= 1'b1;
                            r_state    <= S_ADDR;
                        end else if (rx_data == c_CMD_READ) begin
                            r_is_write <= 1'b0;
                            r_state    <= S_ADDR;
                        end else begin
                            // Unknown command: single 0xFF byte, no bus access.
                            r_resp_left <= 3'd0;
                            tx_data     <= c_ST_BAD_CMD;
                            tx_valid    <= 1'b1;
                            rx_ready    <= 1'b0;
                            r_state     <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (w_rx_fire) begin
                        // LSB-first field: new byte enters at the top, so
                        // after four bytes the first one sits in [7:0].
                        wb_adr     <= {rx_data, wb_adr[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            if (r_is_write) begin
                                r_state <= S_WDATA;
                            end else begin
                                wb_cyc   <= 1'b1;
                                wb_stb   <= 1'b1;
                                wb_we    <= 1'b0;
                                r_tcount <= '0;
                                rx_ready <= 1'b0;
                                r_state  <= S_REQ;
                            end
                        end
                    end
                end

                S_WDATA: begin
                    if (w_rx_fire) begin
                        wb_dat_m   <= {rx_data, wb_dat_m[31:8]};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            wb_cyc   <= 1'b1;
                            wb_stb   <= 1'b1;
                            wb_we    <= 1'b1;
                            r_tcount <= '0;
                            rx_ready <= 1'b0;
                            r_state  <= S_REQ;
                        end
                    end
                end

                S_REQ, S_WAIT: begin
                    if (w_terminate) begin
                        // ack/err are only looked at here, i.e. while cyc=1.
                        wb_cyc      <= 1'b0;
                        wb_stb      <= 1'b0;
                        tx_data     <= w_status;
                        tx_valid    <= 1'b1;
                        r_resp_left <= r_is_write ? 3'd0 : 3'd4;
                        // Failed reads return zero bytes, not stale bus data.
                        r_rdata     <= (wb_ack && !r_is_write) ? wb_dat_s : 32'd0;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcount <= r_tcount + 1'b1;
                        if ((r_state == S_REQ) && !wb_stall) begin
                            // Request accepted: strobe drops, cycle stays open.
                            wb_stb  <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_RESP: begin
                    if (w_tx_fire) begin
                        if (r_resp_left == 3'd0) begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            tx_data     <= r_rdata[7:0];
                            r_rdata     <= {8'd0, r_rdata[31:8]};
                            r_resp_left <= r_resp_left - 3'd1;
                        end
                    end
                end

                default: begin
                    wb_cyc   <= 1'b0;
                    wb_stb   <= 1'b0;
                    tx_valid <= 1'b0;
                    rx_ready <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
